// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: drives a 1-cycle-latency instruction memory, buffers up to two
// returned words with their PCs, and hands them to decode over valid/ready.
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,

    output logic [31:0] imem_addr,
    output logic        imem_renable,
    input  logic [31:0] imem_rdata,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    logic [31:0]  pc_q;
    logic         req_q;
    logic [31:0]  req_pc_q;
    fetch_entry_t buf_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;

    logic         pop;
    logic         push;
    logic [2:0]   occupancy;

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        imem_addr    = pc_q;
        if_valid     = 1'b0;
        if_pc        = 32'h0;
        if_instr     = 32'h0;
        pop          = 1'b0;
        push         = 1'b0;
        occupancy    = 3'd0;
        imem_renable = 1'b0;

        if (!rst && count_q != 2'd0) begin
            if_pc    = buf_q[rd_ptr_q].pc;
            if_instr = buf_q[rd_ptr_q].instr;
        end

        if_valid = !rst && !redirect_valid && (count_q != 2'd0);
        pop      = if_valid && if_ready;
        push     = req_q && !redirect_valid;

        // Words already buffered plus the one in flight, minus the one leaving now,
        // must leave room for the word a new request would return.
        occupancy    = {1'b0, count_q} + {2'b00, req_q} - {2'b00, pop};
        imem_renable = !rst && !redirect_valid && (occupancy < DEPTH_L);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else if (redirect_valid) begin
            // In-flight data is dropped by clearing req_q; the target is re-fetched next cycle.
            pc_q     <= redirect_pc & ~32'h3;
            req_q    <= 1'b0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (imem_renable) begin
                req_q    <= 1'b1;
                req_pc_q <= pc_q;
                pc_q     <= pc_q + 32'd4;
            end else begin
                req_q <= 1'b0;
            end

            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: buffer storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_q[wr_ptr_q] <= '{pc: req_pc_q, instr: imem_rdata};
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for reset/streaming, hand sequences for stall,
// redirect and mid-stream reset, plus a handshake scoreboard of expected PCs.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;

    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc;
    logic        imem_renable, if_valid;

    logic [31:0] w_imem_addr, w_imem_rdata, w_if_instr, w_if_pc;
    logic        w_imem_renable, w_if_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_renable(imem_renable), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
    );

    // Second instance starting near the top of the address space to see the PC wrap.
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_addr(w_imem_addr), .imem_renable(w_imem_renable), .imem_rdata(w_imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(w_if_valid), .if_ready(if_ready), .if_instr(w_if_instr), .if_pc(w_if_pc)
    );

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return {a[31:2], 2'b11} ^ 32'h3C00_0000;
    endfunction

    // Synchronous-read instruction memories, one cycle of latency.
    always @(posedge clk) begin
        if (imem_renable)   imem_rdata   <= instr_at(imem_addr);
        if (w_imem_renable) w_imem_rdata <= instr_at(w_imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start, input int n);
        sb_q.delete();
        for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
    endtask

    task automatic sb_monitor();
        logic [31:0] exp_pc;
        if (if_valid === 1'b1 && if_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got handshake pc %h expected none", if_pc);
            end else begin
                exp_pc = sb_q.pop_front();
                check("sb_pc", if_pc, exp_pc);
                check("sb_instr", if_instr, instr_at(exp_pc));
            end
        end
    endtask

    task automatic sb_drained(input string name);
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst            = r;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        sb_monitor();
    endtask

    task automatic expect_out(input string name, input logic ren, input logic [31:0] addr,
                              input logic valid, input logic empty, input logic [31:0] pc);
        check({name, "_ren"},   {31'b0, imem_renable}, {31'b0, ren});
        check({name, "_addr"},  imem_addr, addr);
        check({name, "_valid"}, {31'b0, if_valid}, {31'b0, valid});
        check({name, "_pc"},    if_pc, empty ? 32'h0 : pc);
        check({name, "_instr"}, if_instr, empty ? 32'h0 : instr_at(pc));
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        exp_ren;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_wpc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{rst: 1'b1, rdy: 1'b1, exp_ren: 1'b0, exp_addr: 32'h0, exp_valid: 1'b0,
                   exp_pc: 32'h0, exp_wpc: 32'h0};
        tbl[1] = '{rst: 1'b0, rdy: 1'b1, exp_ren: 1'b1, exp_addr: 32'h0, exp_valid: 1'b0,
                   exp_pc: 32'h0, exp_wpc: 32'h0};
        tbl[2] = '{rst: 1'b0, rdy: 1'b1, exp_ren: 1'b1, exp_addr: 32'h4, exp_valid: 1'b0,
                   exp_pc: 32'h0, exp_wpc: 32'h0};
        for (int k = 3; k < 13; k++) begin
            tbl[k] = '{rst: 1'b0, rdy: 1'b1, exp_ren: 1'b1, exp_addr: 32'(4 * (k - 1)),
                       exp_valid: 1'b1, exp_pc: 32'(4 * (k - 3)),
                       exp_wpc: 32'hFFFF_FFF8 + 32'(4 * (k - 3))};
        end

        rst            = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        drive(1, 0, 0, 32'h0);

        // Reset, start-up latency and ten words of back-to-back streaming.
        sb_restart(32'h0, 10);
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].rdy, 1'b0, 32'h0);
            expect_out($sformatf("tbl%0d", i), tbl[i].exp_ren, tbl[i].exp_addr,
                       tbl[i].exp_valid, !tbl[i].exp_valid, tbl[i].exp_pc);
            check($sformatf("tbl%0d_wvalid", i), {31'b0, w_if_valid}, {31'b0, tbl[i].exp_valid});
            check($sformatf("tbl%0d_wpc", i), w_if_pc, tbl[i].exp_wpc);
        end
        sb_drained("stream_drained");

        // Fill the buffer under backpressure, then a one-cycle reset mid-stream.
        drive(0, 0, 0, 32'h0);  expect_out("fill1", 0, 32'h30, 1, 0, 32'h28);
        drive(0, 0, 0, 32'h0);  expect_out("fill2", 0, 32'h30, 1, 0, 32'h28);
        sb_restart(32'h0, 2);
        drive(1, 1, 0, 32'h0);  expect_out("rst_mid", 0, 32'h30, 0, 1, 32'h0);

        // Restart from RESET_PC, stall five cycles on the first word, then release.
        drive(0, 0, 0, 32'h0);  expect_out("restart0", 1, 32'h0, 0, 1, 32'h0);
        drive(0, 0, 0, 32'h0);  expect_out("restart1", 1, 32'h4, 0, 1, 32'h0);
        drive(0, 0, 0, 32'h0);  expect_out("stall0", 0, 32'h8, 1, 0, 32'h0);
        for (int i = 1; i < 5; i++) begin
            drive(0, 0, 0, 32'h0);
            expect_out($sformatf("stall%0d", i), 0, 32'h8, 1, 0, 32'h0);
        end
        drive(0, 1, 0, 32'h0);  expect_out("release0", 1, 32'h8, 1, 0, 32'h0);
        drive(0, 1, 0, 32'h0);  expect_out("release1", 1, 32'hC, 1, 0, 32'h4);
        sb_drained("stall_drained");

        // Redirect to 0x20 while PC 0x8 is at the head.
        sb_restart(32'h20, 2);
        drive(0, 1, 1, 32'h20); expect_out("redir", 0, 32'h10, 0, 0, 32'h8);
        drive(0, 1, 0, 32'h0);  expect_out("redir_p1", 1, 32'h20, 0, 1, 32'h0);
        drive(0, 1, 0, 32'h0);  expect_out("redir_p2", 1, 32'h24, 0, 1, 32'h0);
        drive(0, 1, 0, 32'h0);  expect_out("redir_p3", 1, 32'h28, 1, 0, 32'h20);
        drive(0, 1, 0, 32'h0);  expect_out("redir_p4", 1, 32'h2C, 1, 0, 32'h24);
        sb_drained("redir_drained");

        // Misaligned redirect with a full buffer and decode ready in the same cycle.
        drive(0, 0, 0, 32'h0);  expect_out("full1", 0, 32'h30, 1, 0, 32'h28);
        drive(0, 0, 0, 32'h0);  expect_out("full2", 0, 32'h30, 1, 0, 32'h28);
        sb_restart(32'h20, 1);
        drive(0, 1, 1, 32'h23); expect_out("misal", 0, 32'h30, 0, 0, 32'h28);
        drive(0, 1, 0, 32'h0);  expect_out("misal_p1", 1, 32'h20, 0, 1, 32'h0);
        drive(0, 1, 0, 32'h0);  expect_out("misal_p2", 1, 32'h24, 0, 1, 32'h0);
        drive(0, 1, 0, 32'h0);  expect_out("misal_p3", 1, 32'h28, 1, 0, 32'h20);
        sb_drained("misal_drained");

        // Back-to-back redirects: the second target wins.
        sb_restart(32'h40, 2);
        drive(0, 1, 1, 32'h100); expect_out("b2b0", 0, 32'h2C, 0, 0, 32'h24);
        drive(0, 1, 1, 32'h40);  expect_out("b2b1", 0, 32'h100, 0, 1, 32'h0);
        drive(0, 1, 0, 32'h0);   expect_out("b2b_p1", 1, 32'h40, 0, 1, 32'h0);
        drive(0, 1, 0, 32'h0);   expect_out("b2b_p2", 1, 32'h44, 0, 1, 32'h0);
        drive(0, 1, 0, 32'h0);   expect_out("b2b_p3", 1, 32'h48, 1, 0, 32'h40);
        drive(0, 1, 0, 32'h0);   expect_out("b2b_p4", 1, 32'h4C, 1, 0, 32'h44);
        drive(0, 0, 0, 32'h0);   expect_out("b2b_hold", 0, 32'h50, 1, 0, 32'h48);
        sb_drained("b2b_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the RV32I core, directly upstream of Instruction_memory and downstream-feeding decode. Generates word addresses and read enables for the synchronous-read instruction memory (1-cycle read latency), captures returned words with their PC into a 2-entry buffer, and presents them to decode over a valid/ready handshake. Handles branch/jump redirects by flushing buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, output buffer entries (fixed at 2; other values unsupported)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
imem_addr  output  32  fetch address to Instruction_memory mem_addr, always word-aligned
imem_renable  output  1  read request to mem_renable; data for this address is valid on imem_rdata in the next cycle
imem_rdata  input  32  instruction word from mem_rdata
redirect_valid  input  1  redirect request from execute (branch taken / jump)
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
if_valid  output  1  buffered instruction available to decode
if_ready  input  1  decode accepts this cycle
if_instr  output  32  instruction at buffer head
if_pc  output  32  PC of if_instr

Behaviour:
- State: pc_q (next address to request), req_q (request issued last edge, data on imem_rdata this cycle), req_pc_q, 2-entry FIFO of {pc, instr}, count (0..2).
- imem_addr = pc_q combinationally. pop = if_valid & if_ready.
- imem_renable = !rst & !redirect_valid & ((count + req_q - pop) < 2). When imem_renable=1 at an edge: req_q<=1, req_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0). Otherwise req_q<=0, pc_q holds.
- Capture: at an edge with req_q=1 and no redirect, push {req_pc_q, imem_rdata}. Push and pop in same edge allowed; count updates by push-pop. Issue rule guarantees no push when full.
- if_valid = (count != 0) & !redirect_valid. if_instr/if_pc = head entry when count!=0, else 32'h0. No bypass from imem_rdata to outputs.
- Latency: request issued in cycle N -> instruction visible on if_* in cycle N+2. Steady state with if_ready=1: one instruction per cycle, no bubbles.
- Backpressure: if_ready=0 holds if_instr/if_pc/if_valid stable; at most 2 buffered + 0 in flight, or 1 buffered + 1 in flight.
- Redirect (priority over everything except rst): at edge with redirect_valid=1: count<=0, req_q<=0 (in-flight data discarded), pc_q<=redirect_pc & ~3. No request and no handshake in that cycle (if_valid forced 0). Next cycle requests redirect target; first redirected instruction on if_* 2 cycles after the redirect edge.
- Back-to-back redirects: last one wins; each resets the sequence.
- Reset: at edge with rst=1: pc_q<=RESET_PC, req_q<=0, count<=0. During rst: imem_renable=0, if_valid=0, if_instr=0, if_pc=0, imem_addr=pc_q. Reset mid-stream discards all buffered and in-flight words; first cycle after rst release requests RESET_PC.
- imem_addr[1:0] always 2'b00.

Test Plan:
- Reset then if_ready=1 with memory preloaded 0x00000013 at 0x0, 0x00100093 at 0x4 ... -> imem_renable high first cycle after reset at addr 0x0; if_valid rises 2 cycles later with if_pc=0x0, if_instr=0x00000013; then if_pc 0x4, 0x8, ... every cycle for 10 words (0x0..0x24).
- Stall: hold if_ready=0 for 5 cycles after first valid -> if_pc stays 0x0, imem_renable drops after 2 words captured, no word lost or duplicated; on release, PCs continue 0x0,0x4,0x8 contiguous.
- Redirect: pulse redirect_valid with redirect_pc=0x20 while streaming at PC 0x8 -> if_valid=0 that cycle and next two, next accepted if_pc=0x20 with mem word at 0x20; no instruction from 0xC/0x10 emitted.
- Redirect with misaligned target 0x23 and simultaneous if_ready=1 plus full buffer -> imem_addr=0x20 next cycle, count=0, no handshake counted in redirect cycle.
- Wrap: RESET_PC=0xFFFF_FFF8 -> if_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted for 1 cycle mid-stream with buffer full -> next cycle if_valid=0, outputs 0, fetch restarts at RESET_PC with 2-cycle latency.
